sram_arbiter: RTL

- Shares the single external 8-bit asynchronous SRAM (19-bit byte address) between two 32-bit word requesters:
  - port 0: GPU/framebuffer side
  - port 1: CPU memory unit
- Arbitrates round-robin between the two ports.
- Splits each word access into up to four byte cycles and drives SRAM_CSn/WEn/OEn/A.
- Drives the DQ bus through separate out/oe/in signals; the tristate buffer lives in FPGC top level.

---
 rtl/sram_pkg.sv | 31 +++
 rtl/sram_rr_arb2.sv | 34 +++
 rtl/sram_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the SRAM arbiter.
// State encoding, SRAM address width and default access timing.
package sram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      RECOVER,
      DONE
   } state_t;

   localparam int SRAM_BYTE_ADDR_W  = 19;
   localparam int ACCESS_CYCLES_DEF = 2;

   // Lowest set lane of m at or above from; bit 2 flags a hit.
   function automatic logic [2:0] next_lane(
      input logic [3:0] m,
      input logic [2:0] from
   );
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (3'(i) >= from)) begin
            r = {1'b1, 2'(i)};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: two-way round-robin grant.
// Combinational grant, last winner registered on grant.
module sram_rr_arb2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic       gnt_vld,
   output logic       gnt_idx
);

   logic last_grant;

   // On a tie the port that did not win last time is picked.
   always_comb begin
      gnt_vld = en & (|req);
      gnt_idx = 1'b0;
      unique case (1'b1)
         (req == 2'b11): gnt_idx = ~last_grant;
         (req == 2'b10): gnt_idx = 1'b1;
         default:        gnt_idx = 1'b0;
      endcase
   end

   // Remember the winner; reset favours port 0 on the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
      end else if (gnt_vld) begin
         last_grant <= gnt_idx;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 8-bit async SRAM between two word ports.
// Word accesses are split into byte cycles, little-endian.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
   parameter int WORD_ADDR_W   = 17
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        req0,
   input  logic                        we0,
   input  logic [WORD_ADDR_W-1:0]      addr0,
   input  logic [31:0]                 wdata0,
   input  logic [3:0]                  bmask0,
   output logic                        ack0,
   output logic [31:0]                 rdata0,
   input  logic                        req1,
   input  logic                        we1,
   input  logic [WORD_ADDR_W-1:0]      addr1,
   input  logic [31:0]                 wdata1,
   input  logic [3:0]                  bmask1,
   output logic                        ack1,
   output logic [31:0]                 rdata1,
   output logic                        sram_csn,
   output logic                        sram_wen,
   output logic                        sram_oen,
   output logic [SRAM_BYTE_ADDR_W-1:0] sram_a,
   output logic [7:0]                  sram_dq_out,
   output logic                        sram_dq_oe,
   input  logic [7:0]                  sram_dq_in
);

   state_t state, state_nx;

   logic                   gnt_vld;
   logic                   gnt_idx;
   logic                   sel;
   logic                   we_q;
   logic [WORD_ADDR_W-1:0] addr_q;
   logic [31:0]            wdata_q;
   logic [3:0]             mask_q;
   logic [31:0]            rbuf;
   logic [31:0]            rnew;
   logic [2:0]             cnt;
   logic [1:0]             lane;

   logic                   sel_we;
   logic [WORD_ADDR_W-1:0] sel_addr;
   logic [31:0]            sel_wdata;
   logic [3:0]             sel_mask;
   logic [2:0]             first;
   logic [2:0]             nxt;
   logic [3:0]             eff_mask;
   logic                   acc_last;
   logic                   rd_last;
   logic [7:0]             wbyte;

   sram_rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (state == IDLE),
      .req     ({req1, req0}),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   assign sel_we    = gnt_idx ? we1    : we0;
   assign sel_addr  = gnt_idx ? addr1  : addr0;
   assign sel_wdata = gnt_idx ? wdata1 : wdata0;
   assign sel_mask  = gnt_idx ? bmask1 : bmask0;

   assign first    = next_lane(sel_we ? sel_mask : 4'hf, 3'd0);
   assign eff_mask = we_q ? mask_q : 4'hf;
   assign nxt      = next_lane(eff_mask, {1'b0, lane} + 3'd1);
   assign acc_last = (cnt == 3'(ACCESS_CYCLES - 1));
   assign rd_last  = (state == ACCESS) && acc_last && !we_q;
   assign wbyte    = wdata_q[8*lane +: 8];
   assign sram_a   = {addr_q, lane};

   // Merge the byte being sampled into the read word.
   always_comb begin
      rnew = rbuf;
      rnew[8*lane +: 8] = sram_dq_in;
   end

   // State register; reset drops any transfer in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and SRAM strobes / acks decoded from state.
   always_comb begin
      state_nx    = state;
      sram_csn    = 1'b1;
      sram_wen    = 1'b1;
      sram_oen    = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_dq_out = 8'h00;
      ack0        = 1'b0;
      ack1        = 1'b0;
      unique case (state)
         IDLE: begin
            if (gnt_vld) begin
               state_nx = first[2] ? SETUP : DONE;
            end
         end
         SETUP: begin
            sram_csn = 1'b0;
            if (we_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = wbyte;
            end
            state_nx = ACCESS;
         end
         ACCESS: begin
            sram_csn = 1'b0;
            if (we_q) begin
               sram_wen    = 1'b0;
               sram_dq_oe  = 1'b1;
               sram_dq_out = wbyte;
            end else begin
               sram_oen = 1'b0;
            end
            if (acc_last) begin
               if (we_q) begin
                  state_nx = RECOVER;
               end else begin
                  state_nx = nxt[2] ? SETUP : DONE;
               end
            end
         end
         RECOVER: begin
            sram_csn    = 1'b0;
            sram_dq_oe  = 1'b1;
            sram_dq_out = wbyte;
            state_nx    = nxt[2] ? SETUP : DONE;
         end
         DONE: begin
            ack0     = ~sel;
            ack1     = sel;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Request latch, byte sequencing and read assembly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel     <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         lane    <= 2'd0;
         cnt     <= 3'd0;
         rbuf    <= '0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         if ((state == IDLE) && gnt_vld) begin
            sel     <= gnt_idx;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            mask_q  <= sel_mask;
            lane    <= first[1:0];
         end
         if (state == SETUP) begin
            cnt <= 3'd0;
         end else if ((state == ACCESS) && !acc_last) begin
            cnt <= cnt + 3'd1;
         end
         if (rd_last) begin
            rbuf <= rnew;
            if (!nxt[2]) begin
               if (sel) begin
                  rdata1 <= rnew;
               end else begin
                  rdata0 <= rnew;
               end
            end
         end
         if ((rd_last || (state == RECOVER)) && nxt[2]) begin
            lane <= nxt[1:0];
         end
      end
   end

endmodule
